// File: rtl/dma_mem_responder_if.sv
// dma_mem_responder_if: DMA request/grant memory bus.
// Master drives request, address, data and strobes; slave answers.
interface dma_mem_responder_if;
    logic        mem_request;
    logic        mem_grant;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_wr_enable;
    logic        mem_rd_enable;

    modport master (
        output mem_request,
        output mem_addr,
        output mem_wdata,
        output mem_wr_enable,
        output mem_rd_enable,
        input  mem_grant,
        input  mem_rdata
    );

    modport slave (
        input  mem_request,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wr_enable,
        input  mem_rd_enable,
        output mem_grant,
        output mem_rdata
    );
endinterface

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: word RAM behind a request/grant bus with
// optional wait states, access counters and sticky range error.
module dma_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    dma_mem_responder_if.slave    bus,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  range_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    wait_q;
    logic [3:0]    wait_d;
    logic [31:0]   ram [DEPTH];

    logic          in_range;
    logic [AW-1:0] idx;
    logic          access;
    logic          rd_ok;
    logic          wr_ok;

    // Any address bit above the index range makes the access illegal.
    assign in_range = (bus.mem_addr < 32'(DEPTH));
    assign idx      = bus.mem_addr[AW-1:0];
    assign access   = bus.mem_grant & bus.mem_request;
    assign rd_ok    = access & bus.mem_rd_enable;
    assign wr_ok    = access & bus.mem_wr_enable;

    assign bus.mem_grant = (state_q == GRANT);
    assign bus.mem_rdata = (bus.mem_rd_enable && in_range) ?
                           ram[idx] : 32'h0;

    // Arbitration state and wait-state counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: a dropped request always returns to IDLE.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_request) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = GRANT;
                    end else begin
                        state_d = WAIT;
                        wait_d  = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!bus.mem_request) begin
                    state_d = IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d = GRANT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            GRANT: begin
                if (!bus.mem_request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM write port; reset blocks a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset && wr_ok && in_range) begin
            ram[idx] <= bus.mem_wdata;
        end
    end

    // Saturating access counters and sticky range error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
            range_err <= 1'b0;
        end else begin
            if (rd_ok && in_range && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_ok && in_range && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if ((rd_ok || wr_ok) && !in_range) begin
                range_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Memory-side responder for the DMA controller's request/grant bus. It owns a word-addressed RAM and decides when to grant a requesting master. While granted, it serves combinational reads and clock-edge writes. It sits between the DMA master port and on-chip storage, with an optional wait-state delay before each grant. It also provides access counters and a sticky range-error flag for software and bench visibility.

## Interface
- DEPTH, 1024: number of 32-bit words; must be a power of two, ≥ 2.
- WAIT_CYCLES, 0: extra idle cycles between request detection and grant; legal range 0–15.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_request  in  1  master requests the bus; held until the master's transfer phase ends.
- mem_grant  out  1  bus granted to the master.
- mem_addr  in  32  word address (not byte address).
- mem_rdata  out  32  read data.
- mem_wdata  in  32  write data.
- mem_wr_enable  in  1  write strobe.
- mem_rd_enable  in  1  read strobe.
- rd_count  out  16  number of completed in-range reads; saturates at 16'hFFFF.
- wr_count  out  16  number of completed in-range writes; saturates at 16'hFFFF.
- range_err  out  1  sticky flag: an access was attempted with mem_addr ≥ DEPTH.

## Operation
- Reset (reset = 0 at a clock edge):
  - state goes to IDLE.
  - mem_grant = 0, rd_count = 0, wr_count = 0, range_err = 0.
  - RAM contents are not cleared.
- Arbitration FSM:
  - IDLE:
    - mem_request = 1 and WAIT_CYCLES = 0 → GRANT.
    - mem_request = 1 and WAIT_CYCLES > 0 → WAIT, with wait counter loaded to WAIT_CYCLES−1.
  - WAIT:
    - Counter decrements each cycle; at 0 → GRANT.
    - mem_request = 0 at any point → IDLE; no grant is issued.
  - GRANT:
    - mem_grant = 1 (registered output, equals state == GRANT).
    - Stays in GRANT while mem_request = 1.
    - mem_request = 0 → IDLE; mem_grant is 0 the next cycle.
- Access qualification: an access is valid on a clock cycle when mem_grant = 1, mem_request = 1 and the strobe is set.
- Reads:
  - mem_rdata = RAM[mem_addr[log2(DEPTH)-1:0]] combinationally when mem_rd_enable = 1 and mem_addr < DEPTH.
  - In every other case mem_rdata = 32'h0.
  - Reads are not gated by grant at the data path; the count and error updates are gated.
- Writes: on a valid write with in-range address, RAM[index] ← mem_wdata at the rising edge.
- Out-of-range addresses (mem_addr ≥ DEPTH; any upper bit set counts as out of range):
  - Writes are suppressed.
  - Reads return 0.
  - A valid access sets range_err; it stays set until reset.
  - Counters are not incremented.
- Simultaneous rd and wr strobes:
  - The write is performed.
  - mem_rdata shows the old RAM value during that cycle (read-before-write).
  - Both counters increment.
- Counter rules:
  - +1 per valid in-range access cycle; saturates at 16'hFFFF with no wrap.
  - Strobes seen outside GRANT have no effect.

## Timing
- Grant latency from request-assertion edge:
  - WAIT_CYCLES = 0: mem_grant high 1 cycle later.
  - WAIT_CYCLES = N: mem_grant high N+1 cycles later.
- Grant release: mem_grant low 1 cycle after mem_request is sampled low.
- Back-to-back requests: when request drops and rises again, the FSM passes through IDLE for at least 1 cycle, so grant is low for at least 1 cycle.
- Read latency: 0 cycles (combinational from mem_addr and mem_rd_enable).
- Write latency: RAM updated at the edge where the access is valid; readable from the next cycle.
- Counters and range_err update at the same edge as the access.
- Reset mid-GRANT: mem_grant = 0 on the next edge, and a write presented on that edge is discarded.

## Test plan
- Reset and grant latency:
  - Stimulus: WAIT_CYCLES = 0, reset held low 2 cycles, then mem_request = 1.
  - Required: grant = 0 and counters = 0 during reset; mem_grant = 1 exactly one cycle after request; mem_grant = 0 one cycle after request drops.
- Read burst:
  - Stimulus: preload RAM[i] = 32'hA000_0000+i; read addresses 0–3 while granted.
  - Required: mem_rdata = A0000000…A0000003; rd_count = 4; wr_count = 0.
- Write burst:
  - Stimulus: write 0,1,2,3 to addresses 32–35 while granted, then read them back.
  - Required: RAM[32..35] = 0..3; wr_count = 4.
- Wait states:
  - Stimulus: WAIT_CYCLES = 3, request asserted.
  - Required: grant rises 4 cycles after request; a request dropped after 2 cycles yields no grant and the FSM returns to IDLE.
- Range error:
  - Stimulus: DEPTH = 1024; write 32'h1234 to address 1024 while granted.
  - Required: RAM unchanged (RAM[0] still A0000000), range_err = 1 and held, wr_count unchanged; a read at 2000 returns 0.
- Ungranted and simultaneous accesses:
  - Stimulus: wr_enable asserted before grant rises.
  - Required: no write, no count.
  - Stimulus: rd and wr to address 5 in the same granted cycle.
  - Required: rdata = old value, new value visible next cycle, both counters +1.
